sdram_line_arbiter: RTL and testbench

Shares the single SDRAM controller command port between two requesters: the VGA line-fill engine and a CPU word port. The line-fill engine makes 1024-word line requests. The CPU port makes single-word read/write requests. Each video line is split into fixed-size read chunks so a pending CPU access is served between chunks. This bounds CPU latency while the line still completes inside one scanline. The block sits in the `clk_sys` (100 MHz) domain between `vga_controller` and the SDRAM controller.

---
 rtl/sdram_line_arbiter_if.sv | 39 +++
 rtl/sdram_line_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_sdram_line_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_line_arbiter_if.sv
// Signal bundle between the line arbiter, the VGA line-fill engine, the CPU word port and the SDRAM controller.
// The master modport is the arbiter's view; slave is the view of the surrounding requesters and controller.
interface sdram_line_arbiter_if;
    logic        line_req;
    logic [23:0] line_addr;
    logic        line_grant;
    logic [15:0] line_data;
    logic        line_valid;
    logic        line_done;
    logic        cpu_req;
    logic        cpu_we;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic        mem_cmd_we;
    logic [23:0] mem_cmd_addr;
    logic [8:0]  mem_cmd_len;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic [2:0]  arb_state;

    modport master (
        input  line_req, line_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               mem_cmd_ready, mem_rdata, mem_rvalid,
        output line_grant, line_data, line_valid, line_done, cpu_rdata, cpu_ack,
               mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_len, mem_wdata, arb_state
    );

    modport slave (
        output line_req, line_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               mem_cmd_ready, mem_rdata, mem_rvalid,
        input  line_grant, line_data, line_valid, line_done, cpu_rdata, cpu_ack,
               mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_len, mem_wdata, arb_state
    );
endinterface

// File: rtl/sdram_line_arbiter.sv
// Shares the SDRAM command port between chunked video line reads and single CPU words, one CPU access between chunks.
// All outputs registered (read data 1 cycle behind mem_rvalid); commands hold stable while mem_cmd_ready is low.
module sdram_line_arbiter #(
    parameter int LINE_WORDS  = 1024,
    parameter int CHUNK_WORDS = 256
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    sdram_line_arbiter_if.master bus
);
    localparam int              WL_W      = $clog2(LINE_WORDS) + 1;
    localparam logic [WL_W-1:0] LINE_CNT  = WL_W'(LINE_WORDS);
    localparam logic [WL_W-1:0] CHUNK_WL  = WL_W'(CHUNK_WORDS);
    localparam logic [8:0]      CHUNK_LEN = 9'(CHUNK_WORDS);
    localparam logic [23:0]     CHUNK_ADR = 24'(CHUNK_WORDS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        VID_CMD   = 3'd1,
        VID_DATA  = 3'd2,
        CPU_CMD   = 3'd3,
        CPU_RD    = 3'd4,
        VID_DRAIN = 3'd5
    } state_t;

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [8:0]  len;
        logic [15:0] wdata;
    } cmd_t;

    state_t          state_q, state_d;
    logic [23:0]     vid_addr_q, vid_addr_d;
    logic [WL_W-1:0] words_left_q, words_left_d;
    logic [8:0]      chunk_cnt_q, chunk_cnt_d;
    logic            vid_pending_q, vid_pending_d;
    logic            line_hold_q, line_hold_d;
    logic            done_pend_q, done_pend_d;
    logic            line_grant_q, line_grant_d;
    logic            line_valid_q, line_valid_d;
    logic            line_done_q, line_done_d;
    logic [15:0]     line_data_q, line_data_d;
    logic            cpu_ack_q, cpu_ack_d;
    logic [15:0]     cpu_rdata_q, cpu_rdata_d;
    logic            cmd_valid_q, cmd_valid_d;
    cmd_t            cmd_q, cmd_d;
    cmd_t            cpu_cmd;
    logic            cpu_req_live, accept, ret;

    function automatic cmd_t vid_cmd(input logic [23:0] a);
        vid_cmd = '{we: 1'b0, addr: a, len: CHUNK_LEN, wdata: 16'h0000};
    endfunction

    // cpu_req is still high during its own ack cycle and must not start a second access
    assign cpu_req_live = bus.cpu_req && !cpu_ack_q;
    assign accept       = cmd_valid_q && bus.mem_cmd_ready;
    assign cpu_cmd      = '{we: bus.cpu_we, addr: bus.cpu_addr, len: 9'd1, wdata: bus.cpu_wdata};

    always_comb begin
        state_d       = state_q;
        vid_addr_d    = vid_addr_q;
        words_left_d  = words_left_q;
        chunk_cnt_d   = chunk_cnt_q;
        vid_pending_d = vid_pending_q;
        line_hold_d   = line_hold_q && bus.line_req;
        done_pend_d   = 1'b0;
        line_grant_d  = line_grant_q && !line_done_q;
        line_valid_d  = 1'b0;
        line_done_d   = done_pend_q;
        line_data_d   = line_data_q;
        cpu_ack_d     = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_d         = cmd_q;
        ret           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.line_req && !line_grant_q && !line_hold_q) begin
                    state_d      = VID_CMD;
                    vid_addr_d   = bus.line_addr;
                    words_left_d = LINE_CNT;
                    line_grant_d = 1'b1;
                    cmd_valid_d  = 1'b1;
                    cmd_d        = vid_cmd(bus.line_addr);
                end else if (cpu_req_live) begin
                    state_d     = CPU_CMD;
                    cmd_valid_d = 1'b1;
                    cmd_d       = cpu_cmd;
                end
            end
            VID_CMD: begin
                if (accept) begin
                    cmd_valid_d = 1'b0;
                    chunk_cnt_d = CHUNK_LEN;
                    if (bus.line_req) begin
                        state_d = VID_DATA;
                    end else begin
                        state_d      = VID_DRAIN;
                        line_grant_d = 1'b0;
                    end
                end else if (!bus.line_req) begin
                    state_d      = IDLE;
                    cmd_valid_d  = 1'b0;
                    line_grant_d = 1'b0;
                end
            end
            VID_DATA: begin
                if (!bus.line_req) begin
                    state_d       = VID_DRAIN;
                    line_grant_d  = 1'b0;
                    vid_pending_d = 1'b0;
                    if (bus.mem_rvalid) begin
                        chunk_cnt_d = chunk_cnt_q - 9'd1;
                        if (chunk_cnt_q == 9'd1) state_d = IDLE;
                    end
                end else if (bus.mem_rvalid) begin
                    line_valid_d = 1'b1;
                    line_data_d  = bus.mem_rdata;
                    chunk_cnt_d  = chunk_cnt_q - 9'd1;
                    if (chunk_cnt_q == 9'd1) begin
                        vid_addr_d   = vid_addr_q + CHUNK_ADR;
                        words_left_d = words_left_q - CHUNK_WL;
                        if (words_left_q == CHUNK_WL) begin
                            state_d     = IDLE;
                            done_pend_d = 1'b1;
                            line_hold_d = 1'b1;
                        end else if (cpu_req_live) begin
                            state_d       = CPU_CMD;
                            vid_pending_d = 1'b1;
                            cmd_valid_d   = 1'b1;
                            cmd_d         = cpu_cmd;
                        end else begin
                            state_d     = VID_CMD;
                            cmd_valid_d = 1'b1;
                            cmd_d       = vid_cmd(vid_addr_q + CHUNK_ADR);
                        end
                    end
                end
            end
            CPU_CMD: begin
                if (accept) begin
                    cmd_valid_d = 1'b0;
                    if (cmd_q.we) begin
                        cpu_ack_d = 1'b1;
                        ret       = 1'b1;
                    end else begin
                        state_d = CPU_RD;
                    end
                end
            end
            CPU_RD: begin
                if (bus.mem_rvalid) begin
                    cpu_rdata_d = bus.mem_rdata;
                    cpu_ack_d   = 1'b1;
                    ret         = 1'b1;
                end
            end
            VID_DRAIN: begin
                if (bus.mem_rvalid) begin
                    chunk_cnt_d = chunk_cnt_q - 9'd1;
                    if (chunk_cnt_q == 9'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A line abandoned while the CPU held the port releases its grant here
        if (ret) begin
            vid_pending_d = 1'b0;
            if (vid_pending_q && bus.line_req) begin
                state_d     = VID_CMD;
                cmd_valid_d = 1'b1;
                cmd_d       = vid_cmd(vid_addr_q);
            end else begin
                state_d = IDLE;
                if (vid_pending_q) line_grant_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            vid_addr_q    <= '0;
            words_left_q  <= '0;
            chunk_cnt_q   <= '0;
            vid_pending_q <= 1'b0;
            line_hold_q   <= 1'b0;
            done_pend_q   <= 1'b0;
            line_grant_q  <= 1'b0;
            line_valid_q  <= 1'b0;
            line_done_q   <= 1'b0;
            line_data_q   <= '0;
            cpu_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_q         <= '0;
        end else begin
            state_q       <= state_d;
            vid_addr_q    <= vid_addr_d;
            words_left_q  <= words_left_d;
            chunk_cnt_q   <= chunk_cnt_d;
            vid_pending_q <= vid_pending_d;
            line_hold_q   <= line_hold_d;
            done_pend_q   <= done_pend_d;
            line_grant_q  <= line_grant_d;
            line_valid_q  <= line_valid_d;
            line_done_q   <= line_done_d;
            line_data_q   <= line_data_d;
            cpu_ack_q     <= cpu_ack_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_q         <= cmd_d;
        end
    end

    assign bus.line_grant    = line_grant_q;
    assign bus.line_valid    = line_valid_q;
    assign bus.line_data     = line_data_q;
    assign bus.line_done     = line_done_q;
    assign bus.cpu_ack       = cpu_ack_q;
    assign bus.cpu_rdata     = cpu_rdata_q;
    assign bus.mem_cmd_valid = cmd_valid_q;
    assign bus.mem_cmd_we    = cmd_q.we;
    assign bus.mem_cmd_addr  = cmd_q.addr;
    assign bus.mem_cmd_len   = cmd_q.len;
    assign bus.mem_wdata     = cmd_q.wdata;
    assign bus.arb_state     = state_q;
endmodule

// File: tb/tb_sdram_line_arbiter.sv
// Directed bench for sdram_line_arbiter: a negedge SDRAM model answers reads 3 cycles after accept,
// the main sequence drives requesters just after posedge and checks logged commands and counters.
module tb_sdram_line_arbiter;
    logic clk_sys;
    logic rst;

    sdram_line_arbiter_if bus();

    sdram_line_arbiter #(.LINE_WORDS(1024), .CHUNK_WORDS(256)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0, lv_cnt = 0, rv_cnt = 0, done_cnt = 0, ack_cnt = 0, grant_rises = 0, data_err = 0;
    int last_lv_cyc = 0, done_cyc = 0, ack_cyc = 0, line_idx = 0;
    int burst_left = 0, wait_cnt = 0;
    logic [15:0] ack_rdata = 16'h0;
    logic [23:0] cur_base = 24'h0, burst_addr = 24'h0;
    logic        grant_prev = 1'b0;

    logic [23:0] c_addr[$];
    logic [8:0]  c_len[$];
    logic        c_we[$];
    logic [15:0] c_wd[$];
    int          c_cyc[$];

    function automatic logic [15:0] fdat(input logic [23:0] a);
        if (a == 24'h000040) return 16'h1234;
        return a[15:0] ^ 16'hA5C3;
    endfunction

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: summary not reached in time");
        $fatal(1, "watchdog");
    end

    // SDRAM model and output monitor
    initial begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 16'h0;
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (bus.line_grant && !grant_prev) begin
                grant_rises++;
                cur_base = bus.line_addr;
                line_idx = 0;
            end
            grant_prev = bus.line_grant;
            if (bus.line_valid) begin
                if (bus.line_data !== fdat(cur_base + 24'(line_idx))) data_err++;
                line_idx++;
                lv_cnt++;
                last_lv_cyc = cyc;
            end
            if (bus.line_done) begin done_cnt++; done_cyc = cyc; end
            if (bus.cpu_ack) begin ack_cnt++; ack_cyc = cyc; ack_rdata = bus.cpu_rdata; end
            if (rst) begin
                burst_left     = 0;
                wait_cnt       = 0;
                bus.mem_rvalid = 1'b0;
            end else begin
                if (burst_left > 0 && wait_cnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = fdat(burst_addr);
                    burst_addr     = burst_addr + 24'd1;
                    burst_left--;
                    rv_cnt++;
                end else begin
                    bus.mem_rvalid = 1'b0;
                    if (wait_cnt > 0) wait_cnt--;
                end
                if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
                    c_addr.push_back(bus.mem_cmd_addr);
                    c_len.push_back(bus.mem_cmd_len);
                    c_we.push_back(bus.mem_cmd_we);
                    c_wd.push_back(bus.mem_wdata);
                    c_cyc.push_back(cyc);
                    if (!bus.mem_cmd_we) begin
                        burst_addr = bus.mem_cmd_addr;
                        burst_left = int'(bus.mem_cmd_len);
                        wait_cnt   = 2;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string p);
        check({p, "_grant"},  32'(bus.line_grant),    32'h0);
        check({p, "_lvalid"}, 32'(bus.line_valid),    32'h0);
        check({p, "_ldata"},  32'(bus.line_data),     32'h0);
        check({p, "_ldone"},  32'(bus.line_done),     32'h0);
        check({p, "_ack"},    32'(bus.cpu_ack),       32'h0);
        check({p, "_rdata"},  32'(bus.cpu_rdata),     32'h0);
        check({p, "_cvalid"}, 32'(bus.mem_cmd_valid), 32'h0);
        check({p, "_caddr"},  32'(bus.mem_cmd_addr),  32'h0);
        check({p, "_clen"},   32'(bus.mem_cmd_len),   32'h0);
        check({p, "_cwe"},    32'(bus.mem_cmd_we),    32'h0);
        check({p, "_wdata"},  32'(bus.mem_wdata),     32'h0);
        check({p, "_state"},  32'(bus.arb_state),     32'h0);
    endtask

    task automatic check_cmd(input string tag, input int i, input logic we, input logic [23:0] a,
                             input logic [8:0] len, input logic [15:0] wd);
        check({tag, "_we"},   32'(c_we[i]),   32'(we));
        check({tag, "_addr"}, 32'(c_addr[i]), 32'(a));
        check({tag, "_len"},  32'(c_len[i]),  32'(len));
        if (we) check({tag, "_wdata"}, 32'(c_wd[i]), 32'(wd));
    endtask

    task automatic run_line();
        int d0 = done_cnt;
        int a0 = ack_cnt;
        for (int i = 0; i < 4000 && done_cnt == d0; i++) begin
            tick();
            if (ack_cnt != a0) bus.cpu_req = 1'b0;
        end
        bus.line_req = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        int lv0, dn0, ak0, cm0, rv0, gr0;
        rst = 1'b1;
        bus.line_req = 1'b0; bus.line_addr = 24'h0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 24'h0; bus.cpu_wdata = 16'h0;
        bus.mem_cmd_ready = 1'b1;
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();

        // CPU write from idle
        cm0 = c_addr.size(); ak0 = ack_cnt; lv0 = lv_cnt; gr0 = grant_rises;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 24'h000123; bus.cpu_wdata = 16'hBEEF;
        for (int i = 0; i < 100 && ack_cnt == ak0; i++) tick();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        repeat (4) tick();
        check("wr_ncmd", 32'(c_addr.size() - cm0), 32'd1);
        check_cmd("wr_cmd", cm0, 1'b1, 24'h000123, 9'd1, 16'hBEEF);
        check("wr_nack", 32'(ack_cnt - ak0), 32'd1);
        check("wr_ack_cycle", 32'(ack_cyc), 32'(c_cyc[cm0] + 1));
        check("wr_no_line", 32'(lv_cnt - lv0 + grant_rises - gr0), 32'd0);

        // Line only
        cm0 = c_addr.size(); lv0 = lv_cnt; dn0 = done_cnt; gr0 = grant_rises;
        bus.line_addr = 24'h010000; bus.line_req = 1'b1;
        run_line();
        check("line_ncmd", 32'(c_addr.size() - cm0), 32'd4);
        check_cmd("line_c0", cm0,     1'b0, 24'h010000, 9'd256, 16'h0);
        check_cmd("line_c1", cm0 + 1, 1'b0, 24'h010100, 9'd256, 16'h0);
        check_cmd("line_c2", cm0 + 2, 1'b0, 24'h010200, 9'd256, 16'h0);
        check_cmd("line_c3", cm0 + 3, 1'b0, 24'h010300, 9'd256, 16'h0);
        check("line_nvalid", 32'(lv_cnt - lv0), 32'd1024);
        check("line_data_err", 32'(data_err), 32'd0);
        check("line_ndone", 32'(done_cnt - dn0), 32'd1);
        check("line_done_cycle", 32'(done_cyc), 32'(last_lv_cyc + 1));
        check("line_grant_rises", 32'(grant_rises - gr0), 32'd1);
        check("line_grant_low", 32'(bus.line_grant), 32'h0);
        check("line_state_idle", 32'(bus.arb_state), 32'h0);

        // CPU read raised in the middle of chunk 0
        cm0 = c_addr.size(); lv0 = lv_cnt; dn0 = done_cnt; gr0 = grant_rises; ak0 = ack_cnt;
        bus.line_addr = 24'h020000; bus.line_req = 1'b1;
        for (int i = 0; i < 500 && lv_cnt - lv0 < 50; i++) tick();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 24'h000040;
        run_line();
        check("rd_ncmd", 32'(c_addr.size() - cm0), 32'd5);
        check_cmd("rd_c0", cm0,     1'b0, 24'h020000, 9'd256, 16'h0);
        check_cmd("rd_cpu", cm0 + 1, 1'b0, 24'h000040, 9'd1, 16'h0);
        check_cmd("rd_c1", cm0 + 2, 1'b0, 24'h020100, 9'd256, 16'h0);
        check_cmd("rd_c3", cm0 + 4, 1'b0, 24'h020300, 9'd256, 16'h0);
        check("rd_rdata", 32'(ack_rdata), 32'h1234);
        check("rd_nack", 32'(ack_cnt - ak0), 32'd1);
        check("rd_grant_rises", 32'(grant_rises - gr0), 32'd1);
        check("rd_nvalid", 32'(lv_cnt - lv0), 32'd1024);
        check("rd_ndone", 32'(done_cnt - dn0), 32'd1);
        check("rd_data_err", 32'(data_err), 32'd0);

        // Simultaneous line and CPU write requests from idle
        cm0 = c_addr.size(); lv0 = lv_cnt;
        bus.line_addr = 24'h030000; bus.line_req = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 24'h000777; bus.cpu_wdata = 16'h5555;
        run_line();
        check("sim_ncmd", 32'(c_addr.size() - cm0), 32'd5);
        check_cmd("sim_c0", cm0,     1'b0, 24'h030000, 9'd256, 16'h0);
        check_cmd("sim_cpu", cm0 + 1, 1'b1, 24'h000777, 9'd1, 16'h5555);
        check_cmd("sim_c1", cm0 + 2, 1'b0, 24'h030100, 9'd256, 16'h0);
        check_cmd("sim_c2", cm0 + 3, 1'b0, 24'h030200, 9'd256, 16'h0);
        check("sim_nvalid", 32'(lv_cnt - lv0), 32'd1024);

        // Abort after 100 words of chunk 1
        cm0 = c_addr.size(); lv0 = lv_cnt; dn0 = done_cnt; rv0 = rv_cnt;
        bus.line_addr = 24'h040000; bus.line_req = 1'b1;
        for (int i = 0; i < 2000 && rv_cnt - rv0 < 356; i++) tick();
        bus.line_req = 1'b0;
        repeat (300) tick();
        check("abort_nvalid", 32'(lv_cnt - lv0), 32'd356);
        check("abort_nrv", 32'(rv_cnt - rv0), 32'd512);
        check("abort_ncmd", 32'(c_addr.size() - cm0), 32'd2);
        check("abort_ndone", 32'(done_cnt - dn0), 32'd0);
        check("abort_state", 32'(bus.arb_state), 32'h0);
        check("abort_grant", 32'(bus.line_grant), 32'h0);
        check("abort_cvalid", 32'(bus.mem_cmd_valid), 32'h0);
        cm0 = c_addr.size(); lv0 = lv_cnt; dn0 = done_cnt;
        bus.line_addr = 24'h050000; bus.line_req = 1'b1;
        run_line();
        check_cmd("restart_c0", cm0, 1'b0, 24'h050000, 9'd256, 16'h0);
        check("restart_nvalid", 32'(lv_cnt - lv0), 32'd1024);
        check("restart_ndone", 32'(done_cnt - dn0), 32'd1);
        check("restart_data_err", 32'(data_err), 32'd0);

        // Stalled command port, then reset in the middle of chunk data
        cm0 = c_addr.size(); rv0 = rv_cnt;
        bus.mem_cmd_ready = 1'b0;
        bus.line_addr = 24'h060000; bus.line_req = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(bus.mem_cmd_valid), 32'h1);
            check("stall_addr", 32'(bus.mem_cmd_addr), 32'h060000);
            check("stall_len", 32'(bus.mem_cmd_len), 32'd256);
        end
        check("stall_ncmd", 32'(c_addr.size() - cm0), 32'd0);
        bus.mem_cmd_ready = 1'b1;
        for (int i = 0; i < 100 && rv_cnt - rv0 < 20; i++) tick();
        check("pre_reset_state", 32'(bus.arb_state), 32'h2);
        rst = 1'b1;
        #1;
        check_idle("async_reset");
        tick();
        bus.line_req = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check_idle("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
